// File: rtl/counter_sched.sv
// Run-descriptor queue and sequencer for the AXIS counter streamer: pops commands,
// drives the streamer register inputs and paces runs by watching the m_axis handshake.
module counter_sched #(
  parameter int N_FIFO = 3
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              enable,
  input  logic              abort,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [31:0]       cmd_ndata,
  input  logic [31:0]       cmd_nuser,
  input  logic [31:0]       cmd_wait,
  input  logic [15:0]       cmd_gap,
  input  logic [15:0]       cmd_nrep,
  output logic              start_o,
  output logic [31:0]       ndata_o,
  output logic [31:0]       nuser_o,
  output logic [31:0]       wait_o,
  input  logic              mon_tvalid,
  input  logic              mon_tready,
  output logic              busy,
  output logic              done,
  output logic [N_FIFO:0]   fifo_cnt,
  output logic [15:0]       rep_left,
  output logic [1:0]        state_dbg
);

  localparam int DEPTH = 1 << N_FIFO;
  localparam logic [N_FIFO:0] FULL_CNT = (N_FIFO + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t state;

  logic [31:0]       q_ndata [DEPTH];
  logic [31:0]       q_nuser [DEPTH];
  logic [31:0]       q_wait  [DEPTH];
  logic [15:0]       q_gap   [DEPTH];
  logic [15:0]       q_nrep  [DEPTH];
  logic [N_FIFO-1:0] wr_ptr;
  logic [N_FIFO-1:0] rd_ptr;

  logic [15:0] act_gap;
  logic [15:0] gap_cnt;
  logic [31:0] beat_cnt;

  logic full;
  logic push;
  logic pop;
  logic beat;
  logic last_beat;

  // Handshake: a command is taken on any clock where cmd_valid && cmd_ready.
  // cmd_ready drops while full or while abort is held, so nothing slips in during a flush.
  assign full      = (fifo_cnt == FULL_CNT);
  assign cmd_ready = !full && !abort;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && enable && (fifo_cnt != '0) && !abort;
  assign beat      = mon_tvalid && mon_tready;
  assign last_beat = beat && ((beat_cnt + 32'd1) == ndata_o);
  assign state_dbg = state;

  always_ff @(posedge aclk) begin
    if (push) begin
      q_ndata[wr_ptr] <= cmd_ndata;
      q_nuser[wr_ptr] <= cmd_nuser;
      q_wait[wr_ptr]  <= cmd_wait;
      q_gap[wr_ptr]   <= cmd_gap;
      q_nrep[wr_ptr]  <= cmd_nrep;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state    <= IDLE;
      start_o  <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      ndata_o  <= '0;
      nuser_o  <= '0;
      wait_o   <= '0;
      fifo_cnt <= '0;
      rep_left <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      act_gap  <= '0;
      gap_cnt  <= '0;
      beat_cnt <= '0;
    end else if (abort) begin
      state    <= IDLE;
      start_o  <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      fifo_cnt <= '0;
      rep_left <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      done <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;

      case (state)
        IDLE: begin
          if (pop) begin
            ndata_o  <= q_ndata[rd_ptr];
            nuser_o  <= q_nuser[rd_ptr];
            wait_o   <= q_wait[rd_ptr];
            act_gap  <= q_gap[rd_ptr];
            rep_left <= (q_nrep[rd_ptr] == 16'd0) ? 16'd1 : q_nrep[rd_ptr];
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end

        LOAD: begin
          beat_cnt <= '0;
          if (ndata_o == 32'd0) begin
            // Empty run: finishes immediately, then paced exactly like a normal run end.
            done     <= 1'b1;
            rep_left <= rep_left - 16'd1;
            if (act_gap != 16'd0) begin
              gap_cnt <= act_gap - 16'd1;
              state   <= GAP;
            end else if (rep_left > 16'd1) begin
              state <= LOAD;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            start_o <= 1'b1;
            state   <= RUN;
          end
        end

        RUN: begin
          if (last_beat) begin
            start_o  <= 1'b0;
            done     <= 1'b1;
            rep_left <= rep_left - 16'd1;
            if (act_gap != 16'd0) begin
              gap_cnt <= act_gap - 16'd1;
              state   <= GAP;
            end else if (rep_left > 16'd1) begin
              state <= LOAD;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else if (beat) begin
            beat_cnt <= beat_cnt + 32'd1;
          end
        end

        GAP: begin
          if (gap_cnt == 16'd0) begin
            if (rep_left != 16'd0) begin
              state <= LOAD;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched: hand-computed cycle-by-cycle expectations,
// inputs driven and outputs sampled 1 time unit after the rising edge.
module tb_counter_sched;

  logic        aclk = 1'b0;
  logic        areset;
  logic        enable;
  logic        abort;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_ndata;
  logic [31:0] cmd_nuser;
  logic [31:0] cmd_wait;
  logic [15:0] cmd_gap;
  logic [15:0] cmd_nrep;
  logic        start_o;
  logic [31:0] ndata_o;
  logic [31:0] nuser_o;
  logic [31:0] wait_o;
  logic        mon_tvalid;
  logic        mon_tready;
  logic        busy;
  logic        done;
  logic [3:0]  fifo_cnt;
  logic [15:0] rep_left;
  logic [1:0]  state_dbg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [31:0] rep_q[$];

  counter_sched #(.N_FIFO(3)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .enable     (enable),
    .abort      (abort),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ndata  (cmd_ndata),
    .cmd_nuser  (cmd_nuser),
    .cmd_wait   (cmd_wait),
    .cmd_gap    (cmd_gap),
    .cmd_nrep   (cmd_nrep),
    .start_o    (start_o),
    .ndata_o    (ndata_o),
    .nuser_o    (nuser_o),
    .wait_o     (wait_o),
    .mon_tvalid (mon_tvalid),
    .mon_tready (mon_tready),
    .busy       (busy),
    .done       (done),
    .fifo_cnt   (fifo_cnt),
    .rep_left   (rep_left),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_cmd(input logic [31:0] nd, input logic [31:0] nu, input logic [31:0] wt,
                         input logic [15:0] gp, input logic [15:0] nr);
    cmd_ndata = nd;
    cmd_nuser = nu;
    cmd_wait  = wt;
    cmd_gap   = gp;
    cmd_nrep  = nr;
  endtask

  task automatic push_cmd(input logic [31:0] nd, input logic [31:0] nu, input logic [31:0] wt,
                          input logic [15:0] gp, input logic [15:0] nr);
    set_cmd(nd, nu, wt, gp, nr);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_state"}, state_dbg, S_IDLE);
    check({pfx, "_start"}, start_o, 1'b0);
    check({pfx, "_done"}, done, 1'b0);
    check({pfx, "_busy"}, busy, 1'b0);
    check({pfx, "_ndata"}, ndata_o, 32'd0);
    check({pfx, "_nuser"}, nuser_o, 32'd0);
    check({pfx, "_wait"}, wait_o, 32'd0);
    check({pfx, "_fifo"}, fifo_cnt, 4'd0);
    check({pfx, "_rep"}, rep_left, 16'd0);
    check({pfx, "_ready"}, cmd_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  beats;
    int  loads;
    int  hi;
    int  dones;
    bit  started;

    areset = 1'b1; enable = 1'b0; abort = 1'b0; cmd_valid = 1'b0;
    mon_tvalid = 1'b0; mon_tready = 1'b0;
    set_cmd('0, '0, '0, '0, '0);
    tick(); tick();
    check_reset_values("rst");
    areset = 1'b0;
    tick();

    // single run: ndata=4, gap=2, beats every cycle
    enable = 1'b1; mon_tvalid = 1'b1; mon_tready = 1'b1;
    push_cmd(32'd4, 32'hA1, 32'd7, 16'd2, 16'd1);
    check("t1_cnt_after_push", fifo_cnt, 4'd1);
    check("t1_busy_idle", busy, 1'b0);
    tick();
    check("t1_load_state", state_dbg, S_LOAD);
    check("t1_cnt_after_pop", fifo_cnt, 4'd0);
    check("t1_ndata", ndata_o, 32'd4);
    check("t1_nuser", nuser_o, 32'hA1);
    check("t1_wait", wait_o, 32'd7);
    check("t1_start_load", start_o, 1'b0);
    check("t1_rep", rep_left, 16'd1);
    check("t1_busy", busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) check("t1_done_run", done, 1'b0);
      tick();
      check("t1_start_run", start_o, 1'b1);
    end
    tick();
    check("t1_start_end", start_o, 1'b0);
    check("t1_done", done, 1'b1);
    check("t1_gap_state", state_dbg, S_GAP);
    check("t1_rep_end", rep_left, 16'd0);
    tick();
    check("t1_gap2_state", state_dbg, S_GAP);
    check("t1_done_once", done, 1'b0);
    check("t1_start_gap", start_o, 1'b0);
    tick();
    check("t1_idle", state_dbg, S_IDLE);
    check("t1_busy_fall", busy, 1'b0);

    // nrep=3, ndata=5, gap=0, tready toggling
    push_cmd(32'd5, 32'hB2, 32'd0, 16'd0, 16'd3);
    beats = 0; loads = 0; started = 0;
    got_q.delete(); rep_q.delete();
    for (int c = 0; c < 200; c++) begin
      mon_tready = c[0];
      if (state_dbg == S_LOAD) loads++;
      if (state_dbg == S_RUN && mon_tvalid && mon_tready) beats++;
      if (done) begin
        got_q.push_back(beats);
        rep_q.push_back({16'd0, rep_left});
        beats = 0;
      end
      if (busy) started = 1;
      else if (started) break;
      tick();
    end
    check("t2_finished", started && !busy, 1'b1);
    check("t2_loads", loads, 3);
    check("t2_dones", got_q.size(), 3);
    exp_q = '{32'd5, 32'd5, 32'd5};
    for (int i = 0; i < 3 && i < got_q.size(); i++) check("t2_window_beats", got_q[i], exp_q[i]);
    exp_q = '{32'd2, 32'd1, 32'd0};
    for (int i = 0; i < 3 && i < rep_q.size(); i++) check("t2_rep_left", rep_q[i], exp_q[i]);

    // fill the FIFO with enable low, then drain in order (nrep=0 acts as 1)
    enable = 1'b0; mon_tready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      set_cmd(32'd1, 32'd100 + 32'(i), 32'd0, 16'd0, 16'd0);
      cmd_valid = 1'b1;
      check("t3_ready", cmd_ready, (i < 8));
      tick();
    end
    cmd_valid = 1'b0;
    check("t3_full_cnt", fifo_cnt, 4'd8);
    check("t3_ready_full", cmd_ready, 1'b0);
    enable = 1'b1;
    got_q.delete();
    for (int c = 0; c < 300; c++) begin
      if (state_dbg == S_LOAD) got_q.push_back(nuser_o);
      if (fifo_cnt == 4'd0 && !busy && got_q.size() >= 8) break;
      tick();
    end
    check("t3_runs", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) check("t3_order", got_q[i], 32'd100 + 32'(i));
    check("t3_drained", fifo_cnt, 4'd0);
    check("t3_ready_after", cmd_ready, 1'b1);

    // ndata=0, nrep=2
    push_cmd(32'd0, 32'hC4, 32'd0, 16'd1, 16'd2);
    hi = 0; dones = 0; started = 0;
    for (int c = 0; c < 50; c++) begin
      if (start_o) hi++;
      if (done) dones++;
      if (busy) started = 1;
      else if (started) break;
      tick();
    end
    check("t4_no_start", hi, 0);
    check("t4_dones", dones, 2);
    check("t4_idle", started && state_dbg == S_IDLE, 1'b1);

    // abort mid-run with 3 commands queued
    enable = 1'b0; mon_tready = 1'b0;
    push_cmd(32'd10, 32'hD0, 32'd0, 16'd0, 16'd1);
    for (int i = 1; i < 4; i++) push_cmd(32'd3, 32'hD0 + 32'(i), 32'd0, 16'd0, 16'd1);
    check("t5_queued", fifo_cnt, 4'd4);
    enable = 1'b1;
    tick();
    check("t5_load", state_dbg, S_LOAD);
    check("t5_cnt3", fifo_cnt, 4'd3);
    tick();
    check("t5_run", start_o, 1'b1);
    mon_tready = 1'b1;
    tick(); tick();
    mon_tready = 1'b0;
    abort = 1'b1;
    set_cmd(32'd1, 32'hEE, 32'd0, 16'd0, 16'd1);
    cmd_valid = 1'b1;
    #1;
    check("t5_ready_abort", cmd_ready, 1'b0);
    check("t5_still_run", start_o, 1'b1);
    tick();
    abort = 1'b0; cmd_valid = 1'b0;
    check("t5_state", state_dbg, S_IDLE);
    check("t5_start", start_o, 1'b0);
    check("t5_fifo", fifo_cnt, 4'd0);
    check("t5_busy", busy, 1'b0);
    check("t5_done", done, 1'b0);
    check("t5_rep", rep_left, 16'd0);
    tick();
    check("t5_not_accepted", fifo_cnt, 4'd0);
    check("t5_no_done", done, 1'b0);
    check("t5_stay_idle", busy, 1'b0);

    // asynchronous reset in the middle of a gap
    mon_tvalid = 1'b1; mon_tready = 1'b1;
    push_cmd(32'd2, 32'hE0, 32'd9, 16'd10, 16'd1);
    for (int c = 0; c < 20; c++) begin
      if (state_dbg == S_GAP) break;
      tick();
    end
    check("t6_in_gap", state_dbg, S_GAP);
    tick(); tick();
    #3;
    areset = 1'b1;
    #1;
    check_reset_values("t6_async");
    tick();
    #2;
    areset = 1'b0;
    check_reset_values("t6_held");
    push_cmd(32'd3, 32'hE1, 32'd5, 16'd0, 16'd1);
    check("t6_cnt", fifo_cnt, 4'd1);
    tick();
    check("t6_load", state_dbg, S_LOAD);
    check("t6_nuser", nuser_o, 32'hE1);
    tick();
    check("t6_start", start_o, 1'b1);
    tick(); tick();
    check("t6_start_mid", start_o, 1'b1);
    tick();
    check("t6_done", done, 1'b1);
    check("t6_start_end", start_o, 1'b0);
    check("t6_busy_end", busy, 1'b0);
    check("t6_rep_end", rep_left, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/counter_sched.md
# counter_sched

Command-queue scheduler for the AXIS counter streamer. It buffers run descriptors (NDATA, NUSER, WAIT, gap, repeat count) and drives the streamer's START/NDATA/NUSER/WAIT register inputs. It watches the streamer's m_axis handshake to detect the end of each run, then inserts a programmable idle gap and issues the next run. It sits between the control logic (PS registers or the tProcessor) and the counter, in the counter's m_axis clock domain.

## Interface

- N_FIFO, 3: log2 of command FIFO depth (depth 8).
- aclk  in  1  clock (streamer m_axis clock).
- areset  in  1  reset. One clock; reset is asynchronous and active-high.
- enable  in  1  high allows commands to be popped from the FIFO; low stalls only at IDLE.
- abort  in  1  synchronous; flushes the FIFO and ends the current run.
- cmd_valid  in  1  command write strobe.
- cmd_ready  out  1  equals !full && !abort.
- cmd_ndata  in  32  beats per run.
- cmd_nuser  in  32  tuser value passed to the streamer.
- cmd_wait  in  32  streamer inter-beat wait passed to the streamer.
- cmd_gap  in  16  idle cycles after each run.
- cmd_nrep  in  16  repetitions of the command; 0 is treated as 1.
- start_o  out  1  drives streamer START_REG.
- ndata_o  out  32  drives streamer NDATA_REG.
- nuser_o  out  32  drives streamer NUSER_REG.
- wait_o  out  32  drives streamer WAIT_REG.
- mon_tvalid  in  1  streamer m_axis_tvalid tap.
- mon_tready  in  1  streamer m_axis_tready tap.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at the end of each run.
- fifo_cnt  out  N_FIFO+1  number of queued commands.
- rep_left  out  16  runs remaining for the active command, including the current run.

## Operation

- FIFO: push when cmd_valid && cmd_ready. Pop happens only in IDLE. A push and a pop in the same cycle leave fifo_cnt unchanged. A push while full is impossible because cmd_ready is low.
- States:
  - IDLE: when enable=1 and fifo_cnt>0, pop the head and latch it into active registers. Set rep_left = max(nrep,1). Go to LOAD.
  - LOAD: drive ndata_o/nuser_o/wait_o from the active registers; start_o=0; clear the beat counter. If ndata=0, go to GAP and pulse done. Otherwise go to RUN.
  - RUN: start_o=1. The beat counter (32 bit) increments on mon_tvalid&&mon_tready. On the beat that makes the count equal ndata: next cycle start_o=0, done=1, rep_left decrements, and the state goes to GAP. If gap=0, the state goes to the post-gap decision instead.
  - GAP: hold start_o=0 for exactly gap cycles. Post-gap decision: if rep_left>0, go to LOAD with the same command; otherwise go to IDLE.
- Beats seen outside RUN are ignored and do not count.
- Abort: on the next cycle the state is IDLE, start_o=0, the FIFO is empty, rep_left=0, and no done pulse is produced. Abort has priority over every other event.
- ndata_o/nuser_o/wait_o are stable during LOAD, RUN and GAP. They keep their last values in IDLE.

## Timing

- Reset values:
  - state IDLE.
  - start_o=0, done=0, busy=0.
  - ndata_o=nuser_o=wait_o=0.
  - fifo_cnt=0, rep_left=0, cmd_ready=1.
- Command accepted at cycle t → visible in fifo_cnt at t+1 → popped at t+1 if enabled → LOAD at t+2 → start_o=1 at t+3.
- Final beat at cycle b → start_o=0 and done=1 at b+1 → gap cycles b+1..b+gap → LOAD at b+gap+1 (repeat or next command via IDLE, which adds 1 cycle).
- Minimum start_o low time between runs of the same command: gap+1 cycles. Between different commands: gap+2 cycles.
- Beat counter and gap counter do not wrap within a run. ndata up to 2^32-1 is supported.
- All outputs are registered.

## Test plan

- Single command ndata=4, gap=2, nrep=1, beats every cycle → start_o high for exactly 4 beat cycles, done pulse 1 cycle after the 4th beat, start_o low ≥3 cycles, busy falls, fifo_cnt 1→0.
- nrep=3, ndata=5, gap=0, tready toggling 50% → three start_o windows of 5 beats each, rep_left 3→2→1→0, three done pulses, LOAD cycle between windows.
- Push 9 commands with enable=0 → cmd_ready low after 8, fifo_cnt=8. Raise enable → commands are executed in FIFO order, nuser_o sequence matches the write order.
- ndata=0, nrep=2 → no start_o assertion, two done pulses, returns to IDLE.
- Abort mid-RUN after 2 of 10 beats with 3 commands queued → next cycle start_o=0, fifo_cnt=0, busy=0, no done pulse. A cmd_valid during abort is not accepted.
- Assert areset mid-GAP → all outputs at their reset values immediately (asynchronous). After release, operation is normal with a fresh command.
